// File: rtl/dcache_access_unit.sv
// Load/store sequencer between the memory stage and the dcache bus port.
// Splits word-crossing accesses into two beats and extends returned load data.
module dcache_access_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_mctl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  // Mctl encoding shared with the memory stage.
  localparam logic [3:0] MEM_NONE   = 4'h0;
  localparam logic [3:0] MEM_INIT   = 4'h1;
  localparam logic [3:0] MEM_LOAD1  = 4'h2;
  localparam logic [3:0] MEM_LOAD2  = 4'h3;
  localparam logic [3:0] MEM_LOAD4  = 4'h4;
  localparam logic [3:0] MEM_LOAD1U = 4'h5;
  localparam logic [3:0] MEM_LOAD2U = 4'h6;
  localparam logic [3:0] MEM_STORE1 = 4'h7;
  localparam logic [3:0] MEM_STORE2 = 4'h8;
  localparam logic [3:0] MEM_STORE4 = 4'h9;

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  state_t               state_reg, state_next;
  logic [ADDR_W-OW-1:0] word_reg;
  logic [OW-1:0]        off_reg;
  logic [XLEN-1:0]      wdata_reg, beat0_reg, beat1_reg;
  logic [2:0]           width_reg;
  logic                 load_reg, store_reg, signed_reg, cross_reg, err_reg;

  logic       dec_load, dec_store, dec_signed, dec_err;
  logic [2:0] dec_width;

  always_comb begin
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_signed = 1'b0;
    dec_err    = 1'b0;
    dec_width  = 3'd0;
    case (req_mctl)
      MEM_LOAD1:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_width = 3'd1; end
      MEM_LOAD2:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_width = 3'd2; end
      MEM_LOAD4:  begin dec_load = 1'b1; dec_signed = 1'b1; dec_width = 3'd4; end
      MEM_LOAD1U: begin dec_load = 1'b1; dec_width = 3'd1; end
      MEM_LOAD2U: begin dec_load = 1'b1; dec_width = 3'd2; end
      MEM_STORE1: begin dec_store = 1'b1; dec_width = 3'd1; end
      MEM_STORE2: begin dec_store = 1'b1; dec_width = 3'd2; end
      MEM_STORE4: begin dec_store = 1'b1; dec_width = 3'd4; end
      MEM_NONE, MEM_INIT: begin end
      default:    dec_err = 1'b1;
    endcase
  end

  logic [OW-1:0] dec_off;
  logic          dec_cross, misalign_err, dec_skip, accept;

  assign dec_off      = req_addr[OW-1:0];
  assign dec_cross    = ({2'b00, dec_off} + (OW+2)'(dec_width)) > (OW+2)'(NB);
  assign misalign_err = dec_cross && (ALLOW_MISALIGNED == 0);
  // No-ops, errors and forbidden splits answer without touching the bus.
  assign dec_skip     = !(dec_load || dec_store) || misalign_err;
  assign accept       = req_valid && (state_reg == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      word_reg   <= '0;
      off_reg    <= '0;
      wdata_reg  <= '0;
      beat0_reg  <= '0;
      beat1_reg  <= '0;
      width_reg  <= '0;
      load_reg   <= 1'b0;
      store_reg  <= 1'b0;
      signed_reg <= 1'b0;
      cross_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        word_reg   <= req_addr[ADDR_W-1:OW];
        off_reg    <= dec_off;
        wdata_reg  <= req_wdata;
        width_reg  <= dec_width;
        load_reg   <= dec_load;
        store_reg  <= dec_store;
        signed_reg <= dec_signed;
        cross_reg  <= dec_cross;
        err_reg    <= dec_err || misalign_err;
      end
      if (state_reg == WAIT0 && bus_rvalid) beat0_reg <= bus_rdata;
      if (state_reg == WAIT1 && bus_rvalid) beat1_reg <= bus_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = dec_skip ? RESP : ISSUE0;
      ISSUE0:  if (bus_ready) state_next = load_reg ? WAIT0 : (cross_reg ? ISSUE1 : RESP);
      WAIT0:   if (bus_rvalid) state_next = cross_reg ? ISSUE1 : RESP;
      ISSUE1:  if (bus_ready) state_next = load_reg ? WAIT1 : RESP;
      WAIT1:   if (bus_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Both beats come from one double-width view: low half is beat 0, high half beat 1.
  logic [2*NB-1:0]   be_full;
  logic [2*XLEN-1:0] wdata_full;
  logic [ADDR_W-1:0] word_addr;
  logic [XLEN-1:0]   low, keep, ext;
  logic              sign;

  assign be_full    = (((2*NB)'(1) << width_reg) - (2*NB)'(1)) << off_reg;
  assign wdata_full = {{XLEN{1'b0}}, wdata_reg} << {off_reg, 3'b000};
  assign word_addr  = {word_reg, {OW{1'b0}}};
  assign low        = XLEN'({beat1_reg, beat0_reg} >> {off_reg, 3'b000});

  always_comb begin
    keep = XLEN'(32'hFFFF_FFFF);
    sign = low[31];
    case (width_reg)
      3'd1:    begin keep = XLEN'(8'hFF);   sign = low[7];  end
      3'd2:    begin keep = XLEN'(16'hFFFF); sign = low[15]; end
      default: begin end
    endcase
    ext = (low & keep) | ((signed_reg && sign) ? ~keep : '0);
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == RESP);
    resp_err   = resp_valid && err_reg;
    resp_rdata = (resp_valid && load_reg && !err_reg) ? ext : '0;
    bus_valid  = 1'b0;
    bus_wen    = 1'b0;
    bus_addr   = '0;
    bus_be     = '0;
    bus_wdata  = '0;
    if (state_reg == ISSUE0) begin
      bus_valid = 1'b1;
      bus_wen   = store_reg;
      bus_addr  = word_addr;
      bus_be    = be_full[NB-1:0];
      bus_wdata = wdata_full[XLEN-1:0];
    end else if (state_reg == ISSUE1) begin
      bus_valid = 1'b1;
      bus_wen   = store_reg;
      bus_addr  = word_addr + ADDR_W'(NB);
      bus_be    = be_full[2*NB-1:NB];
      bus_wdata = wdata_full[2*XLEN-1:XLEN];
    end
  end
endmodule

// File: tb/tb_dcache_access_unit.sv
// Randomized bench for dcache_access_unit: byte-level memory model, bus responder
// with stalls and variable read latency, plus directed vectors and a strict instance.
module tb_dcache_access_unit;
  localparam logic [3:0] MEM_NONE   = 4'h0;
  localparam logic [3:0] MEM_INIT   = 4'h1;
  localparam logic [3:0] MEM_LOAD1  = 4'h2;
  localparam logic [3:0] MEM_LOAD2  = 4'h3;
  localparam logic [3:0] MEM_LOAD4  = 4'h4;
  localparam logic [3:0] MEM_LOAD1U = 4'h5;
  localparam logic [3:0] MEM_LOAD2U = 4'h6;
  localparam logic [3:0] MEM_STORE1 = 4'h7;
  localparam logic [3:0] MEM_STORE2 = 4'h8;
  localparam logic [3:0] MEM_STORE4 = 4'h9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, resp_valid, resp_err;
  logic [3:0]  req_mctl;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        bus_valid, bus_ready, bus_wen, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  dcache_access_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mctl(req_mctl),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  logic        s_req_valid, s_req_ready, s_resp_valid, s_resp_err;
  logic [3:0]  s_req_mctl;
  logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
  logic        s_bus_valid, s_bus_ready, s_bus_wen, s_bus_rvalid;
  logic [31:0] s_bus_addr, s_bus_wdata, s_bus_rdata;
  logic [3:0]  s_bus_be;

  dcache_access_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_dut_strict (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_mctl(s_req_mctl),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
    .bus_valid(s_bus_valid), .bus_ready(s_bus_ready), .bus_addr(s_bus_addr),
    .bus_wen(s_bus_wen), .bus_be(s_bus_be), .bus_wdata(s_bus_wdata),
    .bus_rvalid(s_bus_rvalid), .bus_rdata(s_bus_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic [7:0]  ref_mem [0:127];   // byte model of 0x100..0x17F
  logic [31:0] bus_mem [0:31];    // responder's word view of the same range
  beat_t       exp_beats[$];

  bit          fast = 1'b1;
  bit          hold_rd = 1'b0;
  int          stall_cnt = 0;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    for (int i = 0; i < 4; i++) ref_mem[addr - 32'h100 + i] = val[8*i +: 8];
    bus_mem[(addr - 32'h100) >> 2] = val;
  endtask

  // Bus responder: random stalls, read data 1..3 cycles after the beat handshake.
  bit          hs_pending = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic        hs_wen;
  logic [31:0] hs_addr, hs_wdata, rd_data;
  logic [3:0]  hs_be;
  int          rd_cnt = 0;

  initial begin
    beat_t b;
    int    idx;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    hs_wen = 1'b0; hs_addr = '0; hs_wdata = '0; hs_be = '0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (hs_pending) begin
        if (exp_beats.size() == 0) check("beat_unexpected", 1, 0);
        else begin
          b = exp_beats.pop_front();
          check("beat_addr", hs_addr, b.addr);
          check("beat_be", hs_be, b.be);
          check("beat_wen", hs_wen, b.wen);
          if (b.wen) check("beat_wdata", hs_wdata & lane_mask(hs_be), b.wdata);
        end
        idx = int'((hs_addr - 32'h100) >> 2);
        if (idx >= 0 && idx < 32) begin
          if (hs_wen) begin
            for (int i = 0; i < 4; i++)
              if (hs_be[i]) bus_mem[idx][8*i +: 8] = hs_wdata[8*i +: 8];
          end else begin
            rd_data = bus_mem[idx];
            rd_cnt  = fast ? 1 : 1 + int'($urandom_range(0, 2));
          end
        end
      end
      hs_pending = 1'b0;
      bus_rvalid = 1'b0;
      if (rd_cnt > 0 && !hold_rd) begin
        rd_cnt--;
        if (rd_cnt == 0) begin bus_rvalid = 1'b1; bus_rdata = rd_data; end
      end
      if (bus_valid && prev_valid && !prev_ready)
        check("bus_hold", {bus_wen, bus_addr, bus_be, bus_wdata}, {hs_wen, hs_addr, hs_be, hs_wdata});
      if (bus_valid) begin
        check("rdy_busy", req_ready, 0);
        hs_wen = bus_wen; hs_addr = bus_addr; hs_be = bus_be; hs_wdata = bus_wdata;
      end
      if (bus_valid && stall_cnt > 0) begin
        bus_ready = 1'b0;
        stall_cnt--;
      end else bus_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
      hs_pending = bus_valid && bus_ready;
      prev_valid = bus_valid;
      prev_ready = bus_ready;
    end
  end

  // One request from an idle slot (posedge+1) to the slot after its response.
  task automatic do_req(input logic [3:0] mctl, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chk_lat, output logic [31:0] got);
    int          w, lat, exp_lat;
    bit          ld, sgn, bad, done;
    logic [31:0] a, v, word, wd0, wd1;
    logic [3:0]  be0, be1;
    w = 0; ld = 0; sgn = 0; bad = 0;
    case (mctl)
      MEM_LOAD1:  begin w = 1; ld = 1; sgn = 1; end
      MEM_LOAD2:  begin w = 2; ld = 1; sgn = 1; end
      MEM_LOAD4:  begin w = 4; ld = 1; sgn = 1; end
      MEM_LOAD1U: begin w = 1; ld = 1; end
      MEM_LOAD2U: begin w = 2; ld = 1; end
      MEM_STORE1: w = 1;
      MEM_STORE2: w = 2;
      MEM_STORE4: w = 4;
      MEM_NONE, MEM_INIT: w = 0;
      default: bad = 1;
    endcase
    be0 = '0; be1 = '0; wd0 = '0; wd1 = '0; v = '0;
    word = addr & ~32'h3;
    for (int i = 0; i < w; i++) begin
      a = addr + i;
      if ((a >> 2) == (addr >> 2)) begin be0[a[1:0]] = 1'b1; wd0[8*a[1:0] +: 8] = wdata[8*i +: 8]; end
      else begin be1[a[1:0]] = 1'b1; wd1[8*a[1:0] +: 8] = wdata[8*i +: 8]; end
      if (ld) v[8*i +: 8] = ref_mem[a - 32'h100];
      else ref_mem[a - 32'h100] = wdata[8*i +: 8];
    end
    if (ld && sgn && v[8*w-1]) for (int i = 8*w; i < 32; i++) v[i] = 1'b1;
    if (!ld) v = '0;
    if (w > 0) begin
      exp_beats.push_back('{wen: !ld, addr: word, be: be0, wdata: ld ? 32'h0 : wd0});
      if (be1 != 0) exp_beats.push_back('{wen: !ld, addr: word + 4, be: be1, wdata: ld ? 32'h0 : wd1});
    end
    exp_lat = (w == 0) ? 1 : (ld ? (be1 != 0 ? 5 : 3) : (be1 != 0 ? 3 : 2));

    req_mctl = mctl; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; done = 0;
    while (!done && lat < 100) begin
      if (resp_valid) done = 1;
      else begin
        req_valid = $urandom_range(0, 1) != 0;   // ignored while busy
        req_mctl = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        @(posedge clk); #1;
        lat++;
      end
    end
    req_valid = 1'b0;
    got = resp_rdata;
    if (!done) check("resp_timeout", 1, 0);
    else begin
      check("resp_rdata", resp_rdata, v);
      check("resp_err", resp_err, bad);
      check("rdy_in_resp", req_ready, 0);
      if (chk_lat) check("latency", lat, exp_lat);
    end
    $display("req mctl=%h addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d", mctl, addr, wdata, got, resp_err, lat);
    @(posedge clk); #1;
    check("resp_pulse", resp_valid, 0);
    check("ready_after", req_ready, 1);
    check("beats_left", exp_beats.size(), 0);
    exp_beats.delete();
  endtask

  logic [3:0] codes [0:12];

  initial begin
    logic [31:0] got;
    int          k;
    codes = '{MEM_LOAD1, MEM_LOAD2, MEM_LOAD4, MEM_LOAD1U, MEM_LOAD2U, MEM_STORE1, MEM_STORE2,
              MEM_STORE4, MEM_LOAD4, MEM_STORE4, MEM_NONE, MEM_INIT, 4'hF};
    rst = 1'b1;
    req_valid = 1'b0; req_mctl = '0; req_addr = '0; req_wdata = '0;
    s_req_valid = 1'b0; s_req_mctl = '0; s_req_addr = '0; s_req_wdata = '0;
    s_bus_ready = 1'b1; s_bus_rvalid = 1'b0; s_bus_rdata = '0;
    for (int i = 0; i < 32; i++) set_word(32'h100 + 4*i, $urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    check("rst_bus", {bus_valid, bus_wen, bus_addr, bus_be, bus_wdata}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with an always-ready bus.
    do_req(MEM_STORE4, 32'h100, 32'hDEADBEEF, 1, got);
    set_word(32'h100, 32'h80112233);
    do_req(MEM_LOAD1, 32'h103, 32'h0, 1, got);  check("lb_vec", got, 32'hFFFFFF80);
    do_req(MEM_LOAD1U, 32'h103, 32'h0, 1, got); check("lbu_vec", got, 32'h00000080);
    do_req(MEM_LOAD2, 32'h102, 32'h0, 1, got);  check("lh_vec", got, 32'hFFFF8011);
    set_word(32'h100, 32'h44332211);
    set_word(32'h104, 32'h88776655);
    do_req(MEM_LOAD4, 32'h102, 32'h0, 1, got);  check("split_lw_vec", got, 32'h66554433);
    do_req(MEM_STORE2, 32'h103, 32'h0000ABCD, 1, got);
    do_req(MEM_LOAD2U, 32'h103, 32'h0, 1, got); check("split_sh_back", got, 32'h0000ABCD);
    do_req(4'hF, 32'h100, 32'h0, 1, got);
    do_req(MEM_NONE, 32'h101, 32'h12345678, 1, got);
    stall_cnt = 5;
    do_req(MEM_STORE4, 32'h108, 32'hCAFEF00D, 0, got);

    // Latency table over random aligned/split accesses, then stalls and slow reads.
    for (int n = 0; n < 300; n++) begin
      fast = (n < 100);
      k = int'($urandom_range(0, 12));
      do_req(codes[k], 32'h100 + $urandom_range(0, 63), $urandom, fast, got);
    end

    // Reset while waiting for read data: the late rvalid must be ignored.
    fast = 1'b1; hold_rd = 1'b1;
    exp_beats.push_back('{wen: 1'b0, addr: 32'h104, be: 4'hF, wdata: 32'h0});
    req_mctl = MEM_LOAD4; req_addr = 32'h104; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_out", {resp_valid, resp_err, resp_rdata, bus_valid, bus_wen, bus_addr, bus_be, bus_wdata}, 0);
    exp_beats.delete();
    @(negedge clk) rst = 1'b0;
    hold_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("late_rvalid", {resp_valid, req_ready, bus_valid}, 3'b010);
    end

    // Strict instance: misaligned and undefined codes answer at once with an error.
    for (int t = 0; t < 2; t++) begin
      s_req_mctl = (t == 0) ? MEM_LOAD4 : 4'hF;
      s_req_addr = 32'h101; s_req_valid = 1'b1;
      @(posedge clk); #1;
      s_req_valid = 1'b0;
      check("strict_resp", {s_resp_valid, s_resp_err, s_bus_valid}, 3'b110);
      check("strict_rdata", s_resp_rdata, 0);
      @(posedge clk); #1;
      check("strict_pulse", {s_resp_valid, s_req_ready, s_bus_valid}, 3'b010);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
